// File: rtl/core_seq_pkg.sv
// Shared types for the core power sequencer: FSM state
// encoding, command opcodes and an elaboration helper.
package core_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_CLK_ON,
    ST_RUN,
    ST_DRAIN,
    ST_RST_ON
  } core_seq_state_e;

  localparam logic CORE_SEQ_OP_START = 1'b1;
  localparam logic CORE_SEQ_OP_STOP  = 1'b0;

  function automatic int unsigned seq_max(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_delay_counter.sv
// Loadable down-counter that saturates at zero.
// Ports: clk_i, rst_i (sync high), load, value[W-1:0], zero.
module seq_delay_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/core_power_sequencer.sv
// Core clock-enable / reset sequencer between the scratchpad
// controller register file and the core clock-gate/reset pins.
// Ports: clk_i, rst_i (sync high), req_valid_i, req_op_i
// (1=START, 0=STOP), req_ready_o, core_idle_i, clk_core_en_o,
// rst_n_core_o, running_o, busy_o, timeout_o.
// Option: define CORE_SEQ_IDLE_TIMEOUT_EN for a drain watchdog.
module core_power_sequencer
  import core_seq_pkg::*;
#(
  parameter int unsigned CLK_TO_RST_CYCLES   = 4,
  parameter int unsigned RST_TO_CLK_CYCLES   = 4,
  parameter int unsigned IDLE_TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_valid_i,
  input  logic req_op_i,
  output logic req_ready_o,
  input  logic core_idle_i,
  output logic clk_core_en_o,
  output logic rst_n_core_o,
  output logic running_o,
  output logic busy_o,
  output logic timeout_o
);

  if (CLK_TO_RST_CYCLES < 1 ||
      RST_TO_CLK_CYCLES < 1 ||
      IDLE_TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("core_power_sequencer: cycle params must be >= 1");
  end

  localparam int unsigned DW =
    $clog2(seq_max(CLK_TO_RST_CYCLES, RST_TO_CLK_CYCLES) + 1);

  localparam logic [DW-1:0] CLK_LOAD =
    DW'(CLK_TO_RST_CYCLES - 1);
  localparam logic [DW-1:0] RST_LOAD =
    DW'(RST_TO_CLK_CYCLES - 1);

  core_seq_state_e state;

  logic          accept;
  logic          start_go;
  logic          stop_go;
  logic          idle_go;
  logic          to_go;
  logic          drain_go;
  logic          dly_load;
  logic [DW-1:0] dly_value;
  logic          dly_zero;

  assign req_ready_o = (state == ST_OFF) ||
                       (state == ST_RUN);

  assign accept   = req_valid_i && req_ready_o;
  assign start_go = accept && (state == ST_OFF) &&
                    (req_op_i == CORE_SEQ_OP_START);
  assign stop_go  = accept && (state == ST_RUN) &&
                    (req_op_i == CORE_SEQ_OP_STOP);
  assign idle_go  = (state == ST_DRAIN) && core_idle_i;
  assign drain_go = idle_go || to_go;

  // One counter times both the power-up and power-down gaps;
  // it is loaded on the transition into CLK_ON or RST_ON.
  assign dly_load  = start_go || drain_go;
  assign dly_value = start_go ? CLK_LOAD : RST_LOAD;

  seq_delay_counter #(
    .W (DW)
  ) u_dly (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load  (dly_load),
    .value (dly_value),
    .zero  (dly_zero)
  );

`ifdef CORE_SEQ_IDLE_TIMEOUT_EN
  localparam int unsigned TW = (IDLE_TIMEOUT_CYCLES > 1) ?
    $clog2(IDLE_TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST =
    TW'(IDLE_TIMEOUT_CYCLES - 1);

  logic [TW-1:0] to_cnt;
  logic          to_flag;

  // Idle wins over the watchdog when both hit the same cycle.
  assign to_go = (state == ST_DRAIN) && !core_idle_i &&
                 (to_cnt == TO_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else begin
      if (stop_go) begin
        to_cnt <= '0;
      end else if (state == ST_DRAIN &&
                   to_cnt != TO_LAST) begin
        to_cnt <= to_cnt + TW'(1);
      end
      if (start_go) begin
        to_flag <= 1'b0;
      end else if (to_go) begin
        to_flag <= 1'b1;
      end
    end
  end

  assign timeout_o = to_flag;
`else
  assign to_go     = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // Outputs change only together with the state register, so
  // each one is a flop and never glitches.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= ST_OFF;
      clk_core_en_o <= 1'b0;
      rst_n_core_o  <= 1'b0;
      running_o     <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      unique case (state)
        ST_OFF: begin
          if (start_go) begin
            state         <= ST_CLK_ON;
            clk_core_en_o <= 1'b1;
            busy_o        <= 1'b1;
          end
        end
        ST_CLK_ON: begin
          if (dly_zero) begin
            state        <= ST_RUN;
            rst_n_core_o <= 1'b1;
            running_o    <= 1'b1;
            busy_o       <= 1'b0;
          end
        end
        ST_RUN: begin
          if (stop_go) begin
            state     <= ST_DRAIN;
            running_o <= 1'b0;
            busy_o    <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_go) begin
            state        <= ST_RST_ON;
            rst_n_core_o <= 1'b0;
          end
        end
        ST_RST_ON: begin
          if (dly_zero) begin
            state         <= ST_OFF;
            clk_core_en_o <= 1'b0;
            busy_o        <= 1'b0;
          end
        end
        default: begin
          state         <= ST_OFF;
          clk_core_en_o <= 1'b0;
          rst_n_core_o  <= 1'b0;
          running_o     <= 1'b0;
          busy_o        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_power_sequencer.sv
// Bench for core_power_sequencer: directed sequences plus a
// random run against a timestamp-based reference model.
module tb_core_power_sequencer;

`ifdef CORE_SEQ_IDLE_TIMEOUT_EN
  localparam bit TO_EN      = 1'b1;
  localparam int DRAIN_WAIT = 5;
`else
  localparam bit TO_EN      = 1'b0;
  localparam int DRAIN_WAIT = 20;
`endif

  localparam int P_OFF   = 0;
  localparam int P_UP    = 1;
  localparam int P_RUN   = 2;
  localparam int P_DRAIN = 3;
  localparam int P_DOWN  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid = 1'b0;
  logic op = 1'b0;
  logic idle = 1'b0;

  logic rdy0, clk0, rstn0, run0, busy0, to0;
  logic rdy1, clk1, rstn1, run1, busy1, to1;

  logic [5:0] act0;
  logic [5:0] act1;
  assign act0 = {rdy0, clk0, rstn0, run0, busy0, to0};
  assign act1 = {rdy1, clk1, rstn1, run1, busy1, to1};

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int m_ph [2];
  int m_dd [2];
  int m_ds [2];
  bit m_to [2];
  int mc   [2] = '{4, 1};
  int mr   [2] = '{4, 1};
  int mt   [2] = '{1024, 8};

  always #5 clk = ~clk;

  core_power_sequencer #(
    .CLK_TO_RST_CYCLES   (4),
    .RST_TO_CLK_CYCLES   (4),
    .IDLE_TIMEOUT_CYCLES (1024)
  ) dut0 (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (valid),
    .req_op_i      (op),
    .req_ready_o   (rdy0),
    .core_idle_i   (idle),
    .clk_core_en_o (clk0),
    .rst_n_core_o  (rstn0),
    .running_o     (run0),
    .busy_o        (busy0),
    .timeout_o     (to0)
  );

  core_power_sequencer #(
    .CLK_TO_RST_CYCLES   (1),
    .RST_TO_CLK_CYCLES   (1),
    .IDLE_TIMEOUT_CYCLES (8)
  ) dut1 (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (valid),
    .req_op_i      (op),
    .req_ready_o   (rdy1),
    .core_idle_i   (idle),
    .clk_core_en_o (clk1),
    .rst_n_core_o  (rstn1),
    .running_o     (run1),
    .busy_o        (busy1),
    .timeout_o     (to1)
  );

  // Reference: phase plus absolute deadline cycle numbers.
  task automatic model_step(input int k);
    if (rst) begin
      m_ph[k] = P_OFF;
      m_to[k] = 1'b0;
      return;
    end
    case (m_ph[k])
      P_OFF: if (valid && op) begin
        m_ph[k] = P_UP;
        m_dd[k] = cyc + mc[k];
        m_to[k] = 1'b0;
      end
      P_UP: if (cyc == m_dd[k]) m_ph[k] = P_RUN;
      P_RUN: if (valid && !op) begin
        m_ph[k] = P_DRAIN;
        m_ds[k] = cyc;
      end
      P_DRAIN: begin
        if (idle) begin
          m_ph[k] = P_DOWN;
          m_dd[k] = cyc + mr[k];
        end else if (TO_EN && cyc - m_ds[k] == mt[k]) begin
          m_ph[k] = P_DOWN;
          m_dd[k] = cyc + mr[k];
          m_to[k] = 1'b1;
        end
      end
      P_DOWN: if (cyc == m_dd[k]) m_ph[k] = P_OFF;
      default: m_ph[k] = P_OFF;
    endcase
  endtask

  function automatic logic [5:0] m_exp(input int k);
    int p;
    p = m_ph[k];
    return {p == P_OFF || p == P_RUN,
            p != P_OFF,
            p == P_RUN || p == P_DRAIN,
            p == P_RUN,
            p == P_UP || p == P_DRAIN || p == P_DOWN,
            m_to[k]};
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) model_step(k);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; idle = 1'b0;
    tick(); tick();
    n_cmp++;
    if (act0 !== 6'b100000 || act1 !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset got=%b/%b exp=100000", act0, act1);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_start();
    valid = 1'b1; op = 1'b1;
    tick();
    valid = 1'b0;
    n_cmp++;
    if (act0 !== 6'b010010 || act1 !== 6'b010010) begin
      n_fail++;
      $display("FAIL start_clk_on got=%b/%b exp=010010",
               act0, act1);
    end
    for (int i = 2; i <= 4; i++) begin
      tick();
      n_cmp++;
      if (act0 !== 6'b010010) begin
        n_fail++;
        $display("FAIL start_wait%0d got=%b exp=010010",
                 i, act0);
      end
      if (i == 2) begin
        n_cmp++;
        if (act1 !== 6'b111100) begin
          n_fail++;
          $display("FAIL min_dly_up got=%b exp=111100", act1);
        end
      end
    end
    tick();
    n_cmp++;
    if (act0 !== 6'b111100) begin
      n_fail++;
      $display("FAIL start_run got=%b exp=111100", act0);
    end
  endtask

  task automatic test_noop_start();
    valid = 1'b1; op = 1'b1;
    n_cmp++;
    if (rdy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL noop_start_rdy got=%b exp=1", rdy0);
    end
    tick();
    valid = 1'b0;
    n_cmp++;
    if (act0 !== 6'b111100 || act1 !== 6'b111100) begin
      n_fail++;
      $display("FAIL noop_start got=%b/%b exp=111100",
               act0, act1);
    end
  endtask

  task automatic test_stop_drain();
    valid = 1'b1; op = 1'b0; idle = 1'b0;
    tick();
    valid = 1'b0;
    n_cmp++;
    if (act0 !== 6'b011010 || act1 !== 6'b011010) begin
      n_fail++;
      $display("FAIL stop_drain got=%b/%b exp=011010",
               act0, act1);
    end
    for (int i = 0; i < DRAIN_WAIT; i++) begin
      tick();
      n_cmp++;
      if (act0 !== 6'b011010 || act1 !== 6'b011010) begin
        n_fail++;
        $display("FAIL drain_hold%0d got=%b/%b exp=011010",
                 i, act0, act1);
      end
    end
    idle = 1'b1;
    tick();
    idle = 1'b0;
    n_cmp++;
    if (act0 !== 6'b010010 || act1 !== 6'b010010) begin
      n_fail++;
      $display("FAIL rst_on got=%b/%b exp=010010",
               act0, act1);
    end
    tick();
    n_cmp++;
    if (act1 !== 6'b100000) begin
      n_fail++;
      $display("FAIL min_dly_down got=%b exp=100000", act1);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (act0 !== 6'b010010) begin
        n_fail++;
        $display("FAIL rst_on_hold%0d got=%b exp=010010",
                 i, act0);
      end
      tick();
    end
    n_cmp++;
    if (act0 !== 6'b100000) begin
      n_fail++;
      $display("FAIL off_again got=%b exp=100000", act0);
    end
  endtask

  task automatic test_noop_stop();
    valid = 1'b1; op = 1'b0;
    tick();
    valid = 1'b0;
    n_cmp++;
    if (act0 !== 6'b100000 || act1 !== 6'b100000) begin
      n_fail++;
      $display("FAIL noop_stop got=%b/%b exp=100000",
               act0, act1);
    end
  endtask

  task automatic test_reset_mid();
    valid = 1'b1; op = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    n_cmp++;
    if (act0 !== 6'b010010) begin
      n_fail++;
      $display("FAIL mid_clk_on got=%b exp=010010", act0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (act0 !== 6'b100000 || act1 !== 6'b100000) begin
      n_fail++;
      $display("FAIL mid_reset got=%b/%b exp=100000",
               act0, act1);
    end
    tick();
    n_cmp++;
    if (act0 !== 6'b100000) begin
      n_fail++;
      $display("FAIL mid_reset_hold got=%b exp=100000", act0);
    end
  endtask

  task automatic test_timeout();
    valid = 1'b1; op = 1'b1;
    tick();
    valid = 1'b0;
    repeat (4) tick();
    valid = 1'b1; op = 1'b0; idle = 1'b0;
    tick();
    valid = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      n_cmp++;
      if (act1 !== 6'b011010) begin
        n_fail++;
        $display("FAIL to_drain%0d got=%b exp=011010", i, act1);
      end
    end
    tick();
    n_cmp++;
    if (act1 !== 6'b010011) begin
      n_fail++;
      $display("FAIL to_fire got=%b exp=010011", act1);
    end
    tick();
    n_cmp++;
    if (act1 !== 6'b100001) begin
      n_fail++;
      $display("FAIL to_sticky got=%b exp=100001", act1);
    end
    valid = 1'b1; op = 1'b1;
    tick();
    valid = 1'b0;
    n_cmp++;
    if (act1 !== 6'b010010 || act0 !== 6'b011010) begin
      n_fail++;
      $display("FAIL to_clear got=%b/%b exp=011010/010010",
               act0, act1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      rst   = ($urandom_range(0, 63) == 0);
      valid = ($urandom_range(0, 3) == 0);
      op    = $urandom_range(0, 1) == 1;
      idle  = ($urandom_range(0, 4) == 0);
      tick();
      n_cmp++;
      if (act0 !== m_exp(0)) begin
        n_fail++;
        $display("FAIL rand0 cyc=%0d got=%b exp=%b",
                 cyc, act0, m_exp(0));
      end
      n_cmp++;
      if (act1 !== m_exp(1)) begin
        n_fail++;
        $display("FAIL rand1 cyc=%0d got=%b exp=%b",
                 cyc, act1, m_exp(1));
      end
    end
    rst = 1'b0; valid = 1'b0; idle = 1'b0;
  endtask

  initial begin
    m_ph = '{P_OFF, P_OFF};
    m_to = '{1'b0, 1'b0};
    m_dd = '{0, 0};
    m_ds = '{0, 0};
    test_reset();
    test_start();
    test_noop_start();
    test_stop_drain();
    test_noop_stop();
    test_reset_mid();
    if (TO_EN) test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/core_power_sequencer.md
CORE_POWER_SEQUENCER -- requirements
Module: core_power_sequencer

Interface
REQ-001 Parameter CLK_TO_RST_CYCLES, default 4: cycles from clock-enable assertion to core reset release; legal range >=1.
REQ-002 Parameter RST_TO_CLK_CYCLES, default 4: cycles from core reset assertion to clock-enable removal; legal range >=1.
REQ-003 Parameter IDLE_TIMEOUT_CYCLES, default 1024: drain watchdog limit; legal range >=1; used only when the macro is defined.
REQ-004 clk_i  input  1  single clock; all logic on rising edge.
REQ-005 rst_i  input  1  synchronous, active-high reset.
REQ-006 req_valid_i  input  1  command request valid.
REQ-007 req_op_i  input  1  command opcode: 1 = START, 0 = STOP.
REQ-008 req_ready_o  output  1  command accept; transfer occurs when valid && ready.
REQ-009 core_idle_i  input  1  core reports no outstanding activity.
REQ-010 clk_core_en_o  output  1  enable to the core clock-gate cell.
REQ-011 rst_n_core_o  output  1  active-low core reset.
REQ-012 running_o  output  1  high only in state RUN.
REQ-013 busy_o  output  1  high in any state other than OFF and RUN.
REQ-014 timeout_o  output  1  sticky drain-timeout flag; cleared by an accepted START.

Function
REQ-015 FSM states SHALL be OFF, CLK_ON, RUN, DRAIN and RST_ON.
REQ-016 req_ready_o SHALL be high exactly in OFF and RUN, combinationally from the state.
REQ-017 START accepted in OFF at cycle t SHALL enter CLK_ON, with clk_core_en_o=1 from t+1.
REQ-018 CLK_ON SHALL load the delay counter with CLK_TO_RST_CYCLES-1, decrement each cycle, and at zero enter RUN, so rst_n_core_o=1 exactly from t+1+CLK_TO_RST_CYCLES.
REQ-019 STOP accepted in RUN SHALL enter DRAIN; clk_core_en_o=1 and rst_n_core_o=1 SHALL hold in DRAIN.
REQ-020 DRAIN SHALL enter RST_ON on the first cycle core_idle_i is sampled 1, with rst_n_core_o=0 from the following cycle.
REQ-021 RST_ON SHALL count RST_TO_CLK_CYCLES cycles as in REQ-018, then enter OFF with clk_core_en_o=0.
REQ-022 START in RUN and STOP in OFF SHALL be accepted as no-ops with no state or output change.
REQ-023 Inputs req_valid_i and core_idle_i SHALL be ignored in CLK_ON, RST_ON and, for req_valid_i, DRAIN.
REQ-024 Outputs clk_core_en_o, rst_n_core_o, running_o, busy_o and timeout_o SHALL be registered and glitch-free.
REQ-025 The delay counter SHALL be sized $clog2(max(CLK_TO_RST_CYCLES, RST_TO_CLK_CYCLES)+1) bits and SHALL never wrap.

Reset
REQ-026 With rst_i high, the state SHALL be OFF, the counters 0, clk_core_en_o=0, rst_n_core_o=0, running_o=0, busy_o=0 and timeout_o=0 in the next cycle.
REQ-027 An rst_i pulse in any state, including mid-count, SHALL abort the sequence immediately with no intermediate output states.

Configuration
REQ-028 With CORE_SEQ_IDLE_TIMEOUT_EN defined, DRAIN SHALL count cycles and, after IDLE_TIMEOUT_CYCLES cycles without core_idle_i, enter RST_ON and set timeout_o.
REQ-029 Without CORE_SEQ_IDLE_TIMEOUT_EN, DRAIN SHALL wait indefinitely, no timeout counter SHALL exist, and timeout_o SHALL be tied to 0.

Structure
REQ-030 Package core_seq_pkg SHALL hold the state enum core_seq_state_e and the opcode constants CORE_SEQ_OP_START and CORE_SEQ_OP_STOP.
REQ-031 The loadable down-counter SHALL be sub-module seq_delay_counter (inputs load and value, output zero), instanced once and shared by CLK_ON and RST_ON.
REQ-032 The block SHALL sit between the scratchpad controller register file and the core clock-gate/reset outputs.

Verification
REQ-033 Reset, then START at cycle 10 -> clk_core_en_o=1 at cycle 11, rst_n_core_o=1 at cycle 15, running_o=1 at cycle 15.
REQ-034 From RUN, STOP with core_idle_i=0 for 20 cycles then 1 -> rst_n_core_o falls one cycle after idle is sampled, clk_core_en_o falls 4 cycles later, req_ready_o=1 in OFF.
REQ-035 START in RUN and STOP in OFF -> each accepted in one cycle with no output change.
REQ-036 rst_i asserted on the second CLK_ON cycle -> next cycle clk_core_en_o=0, rst_n_core_o=0, state OFF.
REQ-037 Macro defined, IDLE_TIMEOUT_CYCLES=8, core_idle_i held 0 after STOP -> RST_ON entered after 8 DRAIN cycles, timeout_o=1 until the next START.
REQ-038 Parameters CLK_TO_RST_CYCLES=1 and RST_TO_CLK_CYCLES=1 -> rst_n_core_o rises one cycle after clk_core_en_o, and clk_core_en_o falls one cycle after rst_n_core_o.
